traffic_light_ctrl: RTL and testbench

- Single-intersection traffic-light sequencer: a three-state Moore FSM cycling RED -> GREEN -> YELLOW -> RED.
- Each state lasts a fixed, parameterised number of enabled clock cycles.
- Drives three one-hot lamp outputs. Used as a simple timing/control leaf block.
- An enable input freezes and resumes the sequence.

---
 rtl/traffic_light_ctrl.sv | 98 +++++++++
 tb/tb_traffic_light_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// Single-intersection traffic-light sequencer: RED -> GREEN -> YELLOW -> RED,
// each state held for a parameterised number of enabled clock cycles.
module traffic_light_ctrl #(
  parameter int unsigned RED_CYCLES    = 32,
  parameter int unsigned GREEN_CYCLES  = 20,
  parameter int unsigned YELLOW_CYCLES = 7,
  parameter int unsigned CNT_W         = 6
) (
  input  logic clk,
  input  logic reset_n,  // active-high despite the name
  input  logic enable,
  output logic red,
  output logic yellow,
  output logic green
);

  typedef enum logic [1:0] {
    S_RED    = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_CYCLES - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       lamps_q, lamps_d;  // {red, yellow, green}

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RED: begin
        if (enable) begin
          if (cnt_q == RED_LAST) begin
            state_d = S_GREEN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_GREEN: begin
        if (enable) begin
          if (cnt_q == GREEN_LAST) begin
            state_d = S_YELLOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_YELLOW: begin
        if (enable) begin
          if (cnt_q == YELLOW_LAST) begin
            state_d = S_RED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      // Illegal encoding recovers regardless of enable.
      default: begin
        state_d = S_RED;
        cnt_d   = '0;
      end
    endcase
  end

  // Lamps are registered from the next state so they always match state_q.
  always_comb begin
    case (state_d)
      S_GREEN:  lamps_d = 3'b001;
      S_YELLOW: lamps_d = 3'b010;
      default:  lamps_d = 3'b100;
    endcase
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q <= S_RED;
      cnt_q   <= '0;
      lamps_q <= 3'b100;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lamps_q <= lamps_d;
    end
  end

  assign red    = lamps_q[2];
  assign yellow = lamps_q[1];
  assign green  = lamps_q[0];

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: default timing, freeze, async reset,
// random enable, and a 1/1/1 parameter override instance.
module tb_traffic_light_ctrl;

  logic clk;
  logic rst, en;
  logic red, yellow, green;
  logic rst1, en1;
  logic red1, yellow1, green1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned k        = 0;
  int unsigned k1       = 0;

  localparam logic [2:0] L_RED    = 3'b100;
  localparam logic [2:0] L_GREEN  = 3'b001;
  localparam logic [2:0] L_YELLOW = 3'b010;

  traffic_light_ctrl u_dut (
    .clk     (clk),
    .reset_n (rst),
    .enable  (en),
    .red     (red),
    .yellow  (yellow),
    .green   (green)
  );

  traffic_light_ctrl #(
    .RED_CYCLES    (1),
    .GREEN_CYCLES  (1),
    .YELLOW_CYCLES (1),
    .CNT_W         (1)
  ) u_dut1 (
    .clk     (clk),
    .reset_n (rst1),
    .enable  (en1),
    .red     (red1),
    .yellow  (yellow1),
    .green   (green1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected lamps after n enabled edges with default 32/20/7 timing.
  function automatic logic [2:0] exp_lamps(input int unsigned n);
    int unsigned m;
    m = n % 59;
    if (m < 32)      return L_RED;
    else if (m < 52) return L_GREEN;
    else             return L_YELLOW;
  endfunction

  function automatic logic [2:0] exp_lamps1(input int unsigned n);
    case (n % 3)
      0:       return L_RED;
      1:       return L_GREEN;
      default: return L_YELLOW;
    endcase
  endfunction

  // One cycle: drive enable, check lamps before the coming edge, advance model.
  task automatic step(input logic e, input string tag);
    en = e;
    check(tag, {29'd0, red, yellow, green}, {29'd0, exp_lamps(k)});
    @(negedge clk);
    if (e) k++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    k = 0;
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b1;
    rst1 = 1'b1;
    en1  = 1'b1;

    // Reset held for two edges with enable high: no advance.
    @(negedge clk);
    check("reset_c0", {29'd0, red, yellow, green}, {29'd0, L_RED});
    check("reset1_c0", {29'd0, red1, yellow1, green1}, {29'd0, L_RED});
    @(negedge clk);
    check("reset_c1", {29'd0, red, yellow, green}, {29'd0, L_RED});
    check("reset1_c1", {29'd0, red1, yellow1, green1}, {29'd0, L_RED});
    rst = 1'b0;
    k = 0;

    // Full cycle, covers boundaries at 31/32, 51/52, 58/59.
    for (int i = 0; i < 130; i++) step(1'b1, $sformatf("full_i%0d", i));

    // Freeze: 10 enabled, 50 paused, then 22 more to reach GREEN.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, "freeze_pre");
    for (int i = 0; i < 50; i++) step(1'b0, "freeze_hold");
    for (int i = 0; i < 22; i++) step(1'b1, "freeze_resume");
    check("freeze_green", {29'd0, red, yellow, green}, {29'd0, L_GREEN});

    // Async reset in GREEN between clock edges.
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b1, "arst_run");
    check("arst_pre_green", {29'd0, red, yellow, green}, {29'd0, L_GREEN});
    en  = 1'b1;
    rst = 1'b1;
    #1;
    check("arst_immediate", {29'd0, red, yellow, green}, {29'd0, L_RED});
    @(negedge clk);
    check("arst_held", {29'd0, red, yellow, green}, {29'd0, L_RED});
    rst = 1'b0;
    k = 0;
    for (int i = 0; i < 32; i++) step(1'b1, "arst_red_dwell");
    check("arst_green_after", {29'd0, red, yellow, green}, {29'd0, L_GREEN});

    // Random enable toggling with one-hot and model checks.
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      check("onehot", $countones({red, yellow, green}), 1);
      step(1'($urandom_range(0, 1)), "rand_model");
    end

    // 1/1/1 override rotates every enabled edge; pause holds.
    en1 = 1'b1;
    rst1 = 1'b0;
    k1 = 0;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("p1_i%0d", i), {29'd0, red1, yellow1, green1}, {29'd0, exp_lamps1(k1)});
      @(negedge clk);
      k1++;
    end
    en1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("p1_hold", {29'd0, red1, yellow1, green1}, {29'd0, exp_lamps1(k1)});
    end
    en1 = 1'b1;
    @(negedge clk);
    k1++;
    check("p1_resume", {29'd0, red1, yellow1, green1}, {29'd0, exp_lamps1(k1)});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
